// File: rtl/mac_column_sequencer.sv
// mac_column_sequencer
//   Sequences one MAC operation per RRAM column, from col_start to col_end.
//   For each column it runs FETCH (reads one input-buffer word), PRECH
//   (precharge, captures the word as the WL mask), EVAL (drives the selected
//   word lines), CONV (clocks the ADC on the column's mux half) and NEXT
//   (reports the column result).
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     start                 launch a sequence (sampled in IDLE only)
//     col_start/col_end     first and last column
//     row_start/row_end     row window (used only with MAC_SEQ_ROW_MASK_EN)
//     if_start_addr         first input-buffer word address
//     busy, done            status, one-cycle completion pulse
//     if_rd_en/if_rd_addr   input-buffer read strobe and address
//     if_data               input-buffer word, valid the cycle after if_rd_en
//     IN0_WL/IN1_WL         WL drive codes (00 selects a row, 11 deselects)
//     PRE                   precharge, active-low
//     ENABLE_WL/BL/SL       line-driver enables
//     S_MUX1/S_MUX2         column mux selects
//     SEL_MUX1/2_TO_ADC     mux-to-ADC passgates
//     CLK_EN_ADC1/2         ADC clock enables
//     col_valid, col_idx    per-column result pulse and its column
//
//   Configuration macro: MAC_SEQ_ROW_MASK_EN
//     defined   -> mask bits outside row_start..row_end are forced to 0
//     undefined -> the full if_data word is used as the mask

module mac_column_sequencer #(
    parameter int ARRAY_SIZE   = 16,
    parameter int IF_SIZE      = 16,
    parameter int ADDR_SIZE_IB = 6,
    parameter int EVAL_CYCLES  = 2,
    parameter int CONV_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              col_start,
    input  logic [3:0]              col_end,
    input  logic [3:0]              row_start,
    input  logic [3:0]              row_end,
    input  logic [ADDR_SIZE_IB-1:0] if_start_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    if_rd_en,
    output logic [ADDR_SIZE_IB-1:0] if_rd_addr,
    input  logic [IF_SIZE-1:0]      if_data,
    output logic [ARRAY_SIZE-1:0]   IN0_WL,
    output logic [ARRAY_SIZE-1:0]   IN1_WL,
    output logic                    PRE,
    output logic                    ENABLE_WL,
    output logic                    ENABLE_BL,
    output logic                    ENABLE_SL,
    output logic [2:0]              S_MUX1,
    output logic [2:0]              S_MUX2,
    output logic                    SEL_MUX1_TO_ADC,
    output logic                    SEL_MUX2_TO_ADC,
    output logic                    CLK_EN_ADC1,
    output logic                    CLK_EN_ADC2,
    output logic                    col_valid,
    output logic [3:0]              col_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PRECH, S_EVAL, S_CONV, S_NEXT, S_DONE
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_col;
    logic [3:0]              r_col_end;
    logic [ADDR_SIZE_IB-1:0] r_addr;
    logic [7:0]              r_cnt;
    logic [ARRAY_SIZE-1:0]   w_mask;

    // The source line is never driven during a read.
    assign ENABLE_SL = 1'b0;

`ifdef MAC_SEQ_ROW_MASK_EN
    logic [3:0] r_row_start;
    logic [3:0] r_row_end;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (i >= int'(r_row_start) && i <= int'(r_row_end)) begin
                w_mask[i] = if_data[i];
            end
        end
    end
`else
    logic w_unused_rows;
    assign w_unused_rows = ^{row_start, row_end};
    assign w_mask        = if_data[ARRAY_SIZE-1:0];
`endif

    // Outputs are registered and set on the transition into the state they
    // belong to, so they line up exactly with r_state. The WL drive registers
    // themselves hold the inverted mask captured at the end of PRECH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_col           <= '0;
            r_col_end       <= '0;
            r_addr          <= '0;
            r_cnt           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            if_rd_en        <= 1'b0;
            if_rd_addr      <= '0;
            IN0_WL          <= '1;
            IN1_WL          <= '1;
            PRE             <= 1'b1;
            ENABLE_WL       <= 1'b0;
            ENABLE_BL       <= 1'b0;
            S_MUX1          <= '0;
            S_MUX2          <= '0;
            SEL_MUX1_TO_ADC <= 1'b0;
            SEL_MUX2_TO_ADC <= 1'b0;
            CLK_EN_ADC1     <= 1'b0;
            CLK_EN_ADC2     <= 1'b0;
            col_valid       <= 1'b0;
            col_idx         <= '0;
`ifdef MAC_SEQ_ROW_MASK_EN
            r_row_start     <= '0;
            r_row_end       <= '0;
`endif
        end else begin
            done      <= 1'b0;
            col_valid <= 1'b0;
            if_rd_en  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col     <= col_start;
                        r_col_end <= col_end;
                        r_addr    <= if_start_addr;
`ifdef MAC_SEQ_ROW_MASK_EN
                        r_row_start <= row_start;
                        r_row_end   <= row_end;
`endif
                        busy      <= 1'b1;
                        // An empty column range completes without touching the array.
                        if (col_end < col_start) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            if_rd_en   <= 1'b1;
                            if_rd_addr <= if_start_addr;
                        end
                    end
                end

                S_FETCH: begin
                    r_state <= S_PRECH;
                    PRE     <= 1'b0;
                    // Columns 0..7 sit behind mux 1, columns 8..15 behind mux 2.
                    if (r_col[3]) begin
                        SEL_MUX2_TO_ADC <= 1'b1;
                        S_MUX2          <= r_col[2:0];
                    end else begin
                        SEL_MUX1_TO_ADC <= 1'b1;
                        S_MUX1          <= r_col[2:0];
                    end
                end

                S_PRECH: begin
                    r_state   <= S_EVAL;
                    r_cnt     <= '0;
                    PRE       <= 1'b1;
                    ENABLE_WL <= 1'b1;
                    ENABLE_BL <= 1'b1;
                    IN0_WL    <= ~w_mask;
                    IN1_WL    <= ~w_mask;
                end

                S_EVAL: begin
                    if (r_cnt == 8'(EVAL_CYCLES - 1)) begin
                        r_state     <= S_CONV;
                        r_cnt       <= '0;
                        ENABLE_WL   <= 1'b0;
                        ENABLE_BL   <= 1'b0;
                        CLK_EN_ADC1 <= ~r_col[3];
                        CLK_EN_ADC2 <= r_col[3];
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_CONV: begin
                    if (r_cnt == 8'(CONV_CYCLES - 1)) begin
                        r_state         <= S_NEXT;
                        r_cnt           <= '0;
                        IN0_WL          <= '1;
                        IN1_WL          <= '1;
                        CLK_EN_ADC1     <= 1'b0;
                        CLK_EN_ADC2     <= 1'b0;
                        SEL_MUX1_TO_ADC <= 1'b0;
                        SEL_MUX2_TO_ADC <= 1'b0;
                        S_MUX1          <= '0;
                        S_MUX2          <= '0;
                        col_valid       <= 1'b1;
                        col_idx         <= r_col;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_NEXT: begin
                    if (r_col == r_col_end) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_col      <= r_col + 4'd1;
                        r_addr     <= r_addr + 1'b1;
                        if_rd_en   <= 1'b1;
                        if_rd_addr <= r_addr + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
